// File: rtl/alu_issue_pkg.sv
// Shared opcode encodings, legality check and sequencer state type
// for the ALU issue controller.
package alu_issue_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } state_t;

  function automatic logic is_legal_opcode(input logic [2:0] op);
    return (op <= OP_DEC);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: r0 reads as zero, two operand read ports,
// one debug read port, one synchronous write port.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 7,
  parameter int unsigned REG_ADDR_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_we,
  input  logic [REG_ADDR_WIDTH:0] i_waddr,
  input  logic [DATA_WIDTH:0]     i_wdata,
  input  logic [REG_ADDR_WIDTH:0] i_raddr1,
  input  logic [REG_ADDR_WIDTH:0] i_raddr2,
  input  logic [REG_ADDR_WIDTH:0] i_raddr_dbg,
  output logic [DATA_WIDTH:0]     o_rdata1,
  output logic [DATA_WIDTH:0]     o_rdata2,
  output logic [DATA_WIDTH:0]     o_rdata_dbg
);

  localparam int unsigned NREGS = 1 << (REG_ADDR_WIDTH + 1);

  logic [DATA_WIDTH:0] r_regs [NREGS];

  // Register storage; writes to r0 are dropped so it stays zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1    = r_regs[i_raddr1];
  assign o_rdata2    = r_regs[i_raddr2];
  assign o_rdata_dbg = r_regs[i_raddr_dbg];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command sequencer in front of the registered ALU: issues operands,
// waits one cycle for the ALU, then writes back result and flags.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH     = 7,
  parameter int unsigned REG_ADDR_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH:0]   cmd_opcode,
  input  logic [REG_ADDR_WIDTH:0] cmd_rd,
  input  logic [REG_ADDR_WIDTH:0] cmd_rs1,
  input  logic [REG_ADDR_WIDTH:0] cmd_rs2,
  input  logic                    cmd_use_imm,
  input  logic [DATA_WIDTH:0]     cmd_imm,
  output logic [OPCODE_WIDTH:0]   alu_opcode,
  output logic [DATA_WIDTH:0]     alu_op1,
  output logic [DATA_WIDTH:0]     alu_op2,
  input  logic [DATA_WIDTH:0]     alu_result,
  input  logic                    alu_carry,
  input  logic                    alu_zero,
  output logic                    wb_valid,
  output logic [REG_ADDR_WIDTH:0] wb_addr,
  output logic [DATA_WIDTH:0]     wb_data,
  output logic                    flag_carry,
  output logic                    flag_zero,
  output logic                    err_illegal,
  input  logic [REG_ADDR_WIDTH:0] rf_raddr,
  output logic [DATA_WIDTH:0]     rf_rdata
);

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_fire;
  logic                    w_legal;
  logic                    w_in_wb;
  logic [DATA_WIDTH:0]     w_rs1_data;
  logic [DATA_WIDTH:0]     w_rs2_data;
  logic [REG_ADDR_WIDTH:0] r_rd;
  logic [OPCODE_WIDTH:0]   r_alu_opcode;
  logic [DATA_WIDTH:0]     r_alu_op1;
  logic [DATA_WIDTH:0]     r_alu_op2;
  logic [REG_ADDR_WIDTH:0] r_wb_addr;
  logic [DATA_WIDTH:0]     r_wb_data;
  logic                    r_flag_carry;
  logic                    r_flag_zero;
  logic                    r_err;

  assign w_legal = is_legal_opcode(3'(cmd_opcode));
  assign w_fire  = cmd_valid && (r_state == IDLE);
  assign w_in_wb = (r_state == WB);

  alu_regfile #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_regfile (
    .clk         (clk),
    .rstn        (rstn),
    .i_we        (w_in_wb),
    .i_waddr     (r_rd),
    .i_wdata     (alu_result),
    .i_raddr1    (cmd_rs1),
    .i_raddr2    (cmd_rs2),
    .i_raddr_dbg (rf_raddr),
    .o_rdata1    (w_rs1_data),
    .o_rdata2    (w_rs2_data),
    .o_rdata_dbg (rf_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state sequencing: IDLE -> EXEC -> WB -> IDLE, or IDLE -> ERR -> IDLE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_fire) w_next = w_legal ? EXEC : ERR;
      EXEC:    w_next = WB;
      WB:      w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand issue, write-back bookkeeping, flags and sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_alu_opcode <= '0;
      r_alu_op1    <= '0;
      r_alu_op2    <= '0;
      r_rd         <= '0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_flag_carry <= 1'b0;
      r_flag_zero  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_fire && w_legal) begin
        r_alu_opcode <= cmd_opcode;
        r_alu_op1    <= w_rs1_data;
        r_alu_op2    <= cmd_use_imm ? cmd_imm : w_rs2_data;
        r_rd         <= cmd_rd;
      end
      if (w_in_wb) begin
        r_wb_addr    <= r_rd;
        r_wb_data    <= alu_result;
        r_flag_carry <= alu_carry;
        r_flag_zero  <= alu_zero;
      end
      if (r_state == ERR) r_err <= 1'b1;
    end
  end

  // The ALU result only exists during WB, so wb_data/wb_addr pass it
  // through in that cycle and hold the captured copy afterwards.
  assign wb_valid    = w_in_wb;
  assign wb_addr     = w_in_wb ? r_rd : r_wb_addr;
  assign wb_data     = w_in_wb ? alu_result : r_wb_data;
  assign cmd_ready   = (r_state == IDLE);
  assign alu_opcode  = r_alu_opcode;
  assign alu_op1     = r_alu_op1;
  assign alu_op2     = r_alu_op2;
  assign flag_carry  = r_flag_carry;
  assign flag_zero   = r_flag_zero;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a registered ALU stub
// and an array-based architectural reference model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid, cmd_ready, cmd_use_imm;
  logic [2:0] cmd_opcode, alu_opcode;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2, wb_addr, rf_raddr;
  logic [7:0] cmd_imm, alu_op1, alu_op2, alu_result, wb_data, rf_rdata;
  logic       alu_carry, alu_zero, wb_valid, flag_carry, flag_zero, err_illegal;

  int n_vec = 0;
  int n_err = 0;

  // Architectural reference state.
  logic [7:0] m_rf [4];
  logic       m_c, m_z, m_err;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .OPCODE_WIDTH   (2),
    .DATA_WIDTH     (7),
    .REG_ADDR_WIDTH (1)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_rd      (cmd_rd),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_use_imm (cmd_use_imm),
    .cmd_imm     (cmd_imm),
    .alu_opcode  (alu_opcode),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .alu_zero    (alu_zero),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flag_carry  (flag_carry),
    .flag_zero   (flag_zero),
    .err_illegal (err_illegal),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata)
  );

  // 9-bit ALU arithmetic: bit 8 is carry/borrow.
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a} + 9'd1;
      3'd3:    return {1'b0, a} - 9'd1;
      default: return 9'd0;
    endcase
  endfunction

  // Registered ALU stub: samples operands each rising edge.
  logic [8:0] alu_q = '0;
  always @(posedge clk) alu_q <= alu_f(alu_opcode, alu_op1, alu_op2);
  assign alu_result = alu_q[7:0];
  assign alu_carry  = alu_q[8];
  assign alu_zero   = (alu_q == 9'd0);

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_c = 1'b0; m_z = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rf_raddr = 2'(i);
      #1;
      chk(tag, {8'h00, rf_rdata}, {8'h00, m_rf[i]});
    end
  endtask

  // Issue one command; cmd_valid is dropped one cycle after the handshake.
  task automatic do_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic ui, input logic [7:0] imm);
    logic [7:0] a, b;
    logic [8:0] r;
    logic       legal;
    int         n;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
    chk("ready_wait", {15'd0, cmd_ready}, 16'd1);
    cmd_opcode = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1'b1;
    legal = (op < 3'd4);
    a = m_rf[rs1];
    b = ui ? imm : m_rf[rs2];
    r = alu_f(op, a, b);
    @(posedge clk);                      // handshake, cycle T
    @(negedge clk);                      // T+1
    cmd_valid = 1'b0;
    chk("ready_t1", {15'd0, cmd_ready}, 16'd0);
    chk("wbv_t1", {15'd0, wb_valid}, 16'd0);
    if (legal) begin
      chk("alu_opc", {13'd0, alu_opcode}, {13'd0, op});
      chk("alu_op1", {8'd0, alu_op1}, {8'd0, a});
      chk("alu_op2", {8'd0, alu_op2}, {8'd0, b});
    end
    @(negedge clk);                      // T+2
    chk("wbv_t2", {15'd0, wb_valid}, {15'd0, legal});
    if (legal) begin
      chk("wb_addr", {14'd0, wb_addr}, {14'd0, rd});
      chk("wb_data", {8'd0, wb_data}, {8'd0, r[7:0]});
      if (rd != 2'd0) m_rf[rd] = r[7:0];
      m_c = r[8];
      m_z = (r == 9'd0);
    end else begin
      m_err = 1'b1;
    end
    @(negedge clk);                      // T+3
    chk("ready_t3", {15'd0, cmd_ready}, 16'd1);
    chk("wbv_t3", {15'd0, wb_valid}, 16'd0);
    chk("flag_c", {15'd0, flag_carry}, {15'd0, m_c});
    chk("flag_z", {15'd0, flag_zero}, {15'd0, m_z});
    chk("err", {15'd0, err_illegal}, {15'd0, m_err});
    rf_raddr = rd;
    #1;
    chk("rf_rd", {8'd0, rf_rdata}, {8'd0, m_rf[rd]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] op;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_rd = '0; cmd_rs1 = '0;
    cmd_rs2 = '0; cmd_use_imm = 1'b0; cmd_imm = '0; rf_raddr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", {15'd0, cmd_ready}, 16'd1);
    chk("rst_wbv", {15'd0, wb_valid}, 16'd0);
    chk("rst_flags", {14'd0, flag_carry, flag_zero}, 16'd0);
    chk("rst_err", {15'd0, err_illegal}, 16'd0);
    chk("rst_alu", {alu_opcode, alu_op1, 5'd0}, 16'd0);
    chk("rst_wb", {6'd0, wb_addr, wb_data}, 16'd0);
    check_regs("rst_rf");
    rstn = 1'b1;

    // 0x80 + 0x80 wraps to 0x00 with carry, zero clear.
    do_cmd(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h80);
    do_cmd(3'd0, 2'd2, 2'd0, 2'd0, 1'b1, 8'h80);
    do_cmd(3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
    chk("add_wrap_c", {15'd0, flag_carry}, 16'd1);
    chk("add_wrap_z", {15'd0, flag_zero}, 16'd0);

    // Subtraction borrow and exact zero.
    do_cmd(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05);
    do_cmd(3'd0, 2'd2, 2'd0, 2'd0, 1'b1, 8'h07);
    do_cmd(3'd1, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
    chk("sub_borrow_r3", {8'd0, m_rf[3]}, 16'h00FE);
    do_cmd(3'd1, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00);
    chk("sub_zero_z", {15'd0, flag_zero}, 16'd1);

    // INC/DEC edges.
    do_cmd(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF);
    do_cmd(3'd2, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00);
    chk("inc_wrap_c", {15'd0, flag_carry}, 16'd1);
    do_cmd(3'd3, 2'd3, 2'd0, 2'd0, 1'b1, 8'h5A);
    chk("dec_r0_c", {15'd0, flag_carry}, 16'd1);

    // Illegal opcode with cmd_valid held: no write-back, sticky error.
    @(negedge clk);
    cmd_opcode = 3'd5; cmd_rd = 2'd1; cmd_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("ill_wbv", {15'd0, wb_valid}, 16'd0);
    end
    cmd_valid = 1'b0;
    m_err = 1'b1;
    repeat (2) @(negedge clk);
    chk("ill_err", {15'd0, err_illegal}, 16'd1);
    chk("ill_flags", {14'd0, flag_carry, flag_zero}, {14'd0, m_c, m_z});
    check_regs("ill_rf");
    do_cmd(3'd0, 2'd2, 2'd0, 2'd0, 1'b1, 8'h33);

    // Reset during EXEC loses the command.
    @(negedge clk);
    cmd_opcode = 3'd0; cmd_rd = 2'd1; cmd_rs1 = 2'd0; cmd_use_imm = 1'b1;
    cmd_imm = 8'h12; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_wbv", {15'd0, wb_valid}, 16'd0);
      chk("rst_mid_ready", {15'd0, cmd_ready}, 16'd1);
      @(negedge clk);
    end
    chk("rst_mid_flags", {13'd0, flag_carry, flag_zero, err_illegal}, 16'd0);
    check_regs("rst_mid_rf");

    // Write to r0: pulse seen, r0 stays zero.
    do_cmd(3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h77);

    // Randomized commands, mostly legal.
    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      do_cmd(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    check_regs("final_rf");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
